// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending-machine timeout countdown.
// Holds the FSM encoding, the BCD digit width and the reload-constant builder.
package vend_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BCD_W = 4;

  // Packs 0..99 as {tens, ones}; only ever evaluated on elaboration constants.
  function automatic logic [2*BCD_W-1:0] to_bcd2(input int v);
    logic [BCD_W-1:0] t;
    logic [BCD_W-1:0] o;
    t = BCD_W'(v / 10);
    o = BCD_W'(v % 10);
    return {t, o};
  endfunction

endpackage

// File: rtl/bcd2_down_counter.sv
// Two-digit BCD down counter with synchronous load; saturates at 00.
// zero_next flags a decrement that will land on 00 at the next edge.
module bcd2_down_counter
  import vend_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [2*BCD_W-1:0] load_val,
  input  logic               dec,
  output logic               zero_next,
  output logic [2*BCD_W-1:0] q
);

  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] ones;

  assign tens      = q[2*BCD_W-1:BCD_W];
  assign ones      = q[BCD_W-1:0];
  assign zero_next = dec && !load && (q == {{(2*BCD_W-1){1'b0}}, 1'b1});

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec && (q != '0)) begin
      if (ones != '0) begin
        q[BCD_W-1:0] <= ones - 1'b1;
      end else begin
        q[BCD_W-1:0]       <= BCD_W'(9);
        q[2*BCD_W-1:BCD_W] <= tens - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_countdown.sv
// Transaction timeout: turns the divider level into second ticks and counts
// TIMEOUT_S down to 00, pulsing expired when the count runs out by ticking.
module vend_countdown
  import vend_pkg::*;
#(
  parameter int TIMEOUT_S = 30
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             tick_lvl,
  input  logic             start,
  input  logic             kick,
  input  logic             pause,
  input  logic             cancel,
  output logic             busy,
  output logic             expired,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones
);

  generate
    if (TIMEOUT_S < 1 || TIMEOUT_S > 99) begin : g_bad_timeout
      $error("vend_countdown: TIMEOUT_S must be 1..99");
    end
  endgenerate

  localparam logic [2*BCD_W-1:0] RELOAD = to_bcd2(TIMEOUT_S);

  state_t             state, state_n;
  logic               tick_q;
  logic               tick;
  logic               load;
  logic [2*BCD_W-1:0] load_val;
  logic               dec;
  logic               zero_next;
  logic [2*BCD_W-1:0] q;

  // tick_lvl is already in the clk domain, so a single register suffices.
  assign tick = tick_lvl & ~tick_q;

  // Counter control, priority cancel > start > kick > tick.
  always_comb begin
    load     = 1'b0;
    load_val = RELOAD;
    dec      = 1'b0;
    if (cancel) begin
      load     = 1'b1;
      load_val = '0;
    end else if (start) begin
      load = 1'b1;
    end else if (kick && state == RUN) begin
      load = 1'b1;
    end else if (tick && state == RUN && !pause) begin
      dec = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    if (cancel)         state_n = IDLE;
    else if (start)     state_n = RUN;
    else if (zero_next) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      tick_q  <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      tick_q  <= tick_lvl;
      expired <= zero_next;
    end
  end

  bcd2_down_counter u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .zero_next(zero_next),
    .q        (q)
  );

  assign busy     = (state == RUN);
  assign sec_tens = q[2*BCD_W-1:BCD_W];
  assign sec_ones = q[BCD_W-1:0];

endmodule

// File: tb/tb_vend_countdown.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and
// compares after each clock edge. Two instances: TIMEOUT_S=3 and TIMEOUT_S=30.
module tb_vend_countdown;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic tick_lvl = 1'b0, start = 1'b0, kick = 1'b0, pause = 1'b0, cancel = 1'b0;
  logic busy3, exp3, busy30, exp30;
  logic [3:0] t3, o3, t30, o30;

  always #5 clk = ~clk;

  vend_countdown #(.TIMEOUT_S(3)) dut3 (
    .clk(clk), .clr(clr), .tick_lvl(tick_lvl), .start(start), .kick(kick),
    .pause(pause), .cancel(cancel), .busy(busy3), .expired(exp3),
    .sec_tens(t3), .sec_ones(o3));

  vend_countdown #(.TIMEOUT_S(30)) dut30 (
    .clk(clk), .clr(clr), .tick_lvl(tick_lvl), .start(start), .kick(kick),
    .pause(pause), .cancel(cancel), .busy(busy30), .expired(exp30),
    .sec_tens(t30), .sec_ones(o30));

  typedef struct packed {
    logic       b;
    logic       e;
    logic [3:0] t;
    logic [3:0] o;
  } obs_t;

  obs_t q3[$];
  obs_t q30[$];
  int   tests = 0, fails = 0;
  int   pulses3 = 0, pulses30 = 0;

  // Reference model: remaining seconds as a plain integer plus a running flag.
  int m_cnt[2];
  bit m_run[2];
  bit m_prev;
  bit lvl;
  int div;

  function automatic int tmo(input int i);
    return (i == 0) ? 3 : 30;
  endfunction

  function automatic obs_t model_step(input int i, input bit tk, input bit st,
                                      input bit kk, input bit ps, input bit cc,
                                      input bit rst);
    bit   e;
    obs_t r;
    e = 1'b0;
    if (rst) begin
      m_cnt[i] = 0; m_run[i] = 1'b0;
    end else if (cc) begin
      m_cnt[i] = 0; m_run[i] = 1'b0;
    end else if (st) begin
      m_cnt[i] = tmo(i); m_run[i] = 1'b1;
    end else if (kk && m_run[i]) begin
      m_cnt[i] = tmo(i);
    end else if (tk && m_run[i] && !ps) begin
      m_cnt[i] = m_cnt[i] - 1;
      if (m_cnt[i] == 0) begin
        m_run[i] = 1'b0; e = 1'b1;
      end
    end
    r.b = m_run[i];
    r.e = e;
    r.t = 4'(m_cnt[i] / 10);
    r.o = 4'(m_cnt[i] % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: one expectation per clock edge for each instance.
  obs_t got3, got30, want3, want30;
  always @(posedge clk) begin
    #1;
    if (q3.size() > 0 && q30.size() > 0) begin
      want3  = q3.pop_front();
      want30 = q30.pop_front();
      got3   = {busy3, exp3, t3, o3};
      got30  = {busy30, exp30, t30, o30};
      if (exp3)  pulses3++;
      if (exp30) pulses30++;
      tests += 2;
      if (got3 !== want3) begin
        fails++;
        $display("FAIL sb_t3 @%0t: got b=%0b e=%0b %0d%0d, required b=%0b e=%0b %0d%0d",
                 $time, got3.b, got3.e, got3.t, got3.o, want3.b, want3.e, want3.t, want3.o);
      end
      if (got30 !== want30) begin
        fails++;
        $display("FAIL sb_t30 @%0t: got b=%0b e=%0b %0d%0d, required b=%0b e=%0b %0d%0d",
                 $time, got30.b, got30.e, got30.t, got30.o, want30.b, want30.e, want30.t, want30.o);
      end
    end
  end

  // Drives one cycle at a negedge and queues what both instances must show after it.
  task automatic step(input bit st, input bit kk, input bit ps, input bit cc,
                      input bit tl, input bit rst = 1'b0);
    bit tk;
    start = st; kick = kk; pause = ps; cancel = cc; tick_lvl = tl; clr = rst;
    tk     = tl && !m_prev && !rst;
    m_prev = rst ? 1'b0 : tl;
    q3.push_back(model_step(0, tk, st, kk, ps, cc, rst));
    q30.push_back(model_step(1, tk, st, kk, ps, cc, rst));
    @(negedge clk);
  endtask

  // Free-running divider stand-in: tick_lvl toggles every 4 clocks.
  task automatic tstep(input bit st, input bit kk, input bit ps, input bit cc);
    div++;
    if (div == 4) begin
      div = 0; lvl = ~lvl;
    end
    step(st, kk, ps, cc, lvl);
  endtask

  task automatic ticks(input int n, input bit ps);
    int  rises;
    bit  old;
    rises = 0;
    while (rises < n) begin
      old = lvl;
      tstep(1'b0, 1'b0, ps, 1'b0);
      if (lvl && !old) rises++;
    end
  endtask

  int base;
  bit rs, rk, rc, rr, rp;

  initial begin
    m_cnt = '{0, 0}; m_run = '{1'b0, 1'b0}; m_prev = 1'b0; lvl = 1'b0; div = 0;
    repeat (2) @(negedge clk);
    chk("reset_t3", {busy3, exp3, t3, o3}, 10'h0);
    chk("reset_t30", {busy30, exp30, t30, o30}, 10'h0);
    step(0, 0, 0, 0, 0, 1);

    // 1: start, 3 ticks -> 03,02,01,00 with one expired pulse
    step(1, 0, 0, 0, 0);
    chk("t1_load", {t3, o3}, 8'h03);
    base = pulses3;
    ticks(3, 0);
    chk("t1_busy_drop", busy3, 0);
    tstep(0, 0, 0, 0); tstep(0, 0, 0, 0);
    chk("t1_one_pulse", pulses3 - base, 1);

    // 2: TIMEOUT_S=30, 21 ticks -> 09 through the 10->09 borrow
    step(1, 0, 0, 0, lvl);
    ticks(21, 0);
    chk("t2_digits", {t30, o30}, 8'h09);
    chk("t2_busy", busy30, 1);

    // 3: kick at 01 reloads, then 3 ticks give a single pulse
    step(1, 0, 0, 0, lvl);
    ticks(2, 0);
    chk("t3_at01", {t3, o3}, 8'h01);
    step(0, 1, 0, 0, lvl);
    chk("t3_kick", {t3, o3}, 8'h03);
    base = pulses3;
    ticks(3, 0);
    tstep(0, 0, 0, 0);
    chk("t3_one_pulse", pulses3 - base, 1);

    // 4: cancel+start+tick -> IDLE/00; start+tick -> 03
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    chk("t4_cancel", {busy3, exp3, t3, o3}, 10'h0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("t4_start_tick", {busy3, t3, o3}, 9'h103);
    lvl = 1'b1; div = 0;

    // 5: pause freezes the count across 5 ticks
    ticks(1, 0);
    chk("t5_pre", {t3, o3}, 8'h02);
    ticks(5, 1);
    chk("t5_frozen", {t3, o3}, 8'h02);
    ticks(1, 0);
    chk("t5_release", {t3, o3}, 8'h01);
    ticks(1, 0);

    // 6: clr mid-cycle at 02, then IDLE ignores ticks and kicks
    step(1, 0, 0, 0, lvl);
    ticks(1, 0);
    #2 clr = 1'b1;
    #1 chk("t6_async_clr", {busy3, exp3, t3, o3}, 10'h0);
    step(0, 0, 0, 0, lvl, 1);
    tstep(0, 1, 0, 0);
    ticks(2, 0);
    tstep(0, 1, 0, 0);
    chk("t6_idle", {busy3, t3, o3, busy30, t30, o30}, 18'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2) == 0) lvl = ~lvl;
      rs = ($urandom_range(39) == 0);
      rk = ($urandom_range(19) == 0);
      rc = ($urandom_range(79) == 0);
      rr = ($urandom_range(299) == 0);
      if ($urandom_range(15) == 0) rp = ~rp;
      step(rs, rk, rp, rc, lvl, rr);
    end

    step(0, 0, 0, 0, lvl);
    @(posedge clk); #2;
    chk("sb_drained", q3.size() + q30.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
